// File: rtl/wb_write_queue_pkg.sv
// Shared types for the register-file writeback queue.
package wb_write_queue_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WORD_W = 32;

    typedef logic [REG_W-1:0]  regidx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic    live;
        regidx_t wa;
        word_t   wd;
    } wb_entry_t;

endpackage

// File: rtl/wbq_lookup.sv
// Forwarding lookup: current primary write first, else the youngest live queued entry.
module wbq_lookup
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   en_i,
    input  wb_entry_t              entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic                   p_valid_i,
    input  regidx_t                p_wa_i,
    input  word_t                  p_wd_i,
    input  regidx_t                ra_i,
    output logic                   hit_o,
    output word_t                  data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (en_i && ra_i != '0) begin
            if (p_valid_i && p_wa_i == ra_i) begin
                hit_o  = 1'b1;
                data_o = p_wd_i;
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    idx = head_i + PTR_W'(i);
                    if (CNT_W'(i) < count_i && entries_i[idx].live &&
                        entries_i[idx].wa == ra_i) begin
                        hit_o  = 1'b1;
                        data_o = entries_i[idx].wd;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Merges zero-latency primary writeback with a buffered secondary stream onto the
// single regfile write port, and forwards not-yet-committed values to two readers.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     p_valid,
    input  logic [4:0]               p_wa,
    input  logic [31:0]              p_wd,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_wa,
    input  logic [31:0]              s_wd,
    output logic [4:0]               wa3,
    output logic                     write_enable,
    output logic [31:0]              wd3,
    input  logic [4:0]               q_ra1,
    input  logic [4:0]               q_ra2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic [31:0]              q_data1,
    output logic [31:0]              q_data2,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic prim_we;
    logic push;
    logic pop;

    assign prim_we = p_valid && (p_wa != '0);
    assign s_ready = resetn && (count_q < CNT_W'(DEPTH));
    assign push    = s_valid && s_ready;
    assign pop     = resetn && !p_valid && (count_q != '0);
    assign pending = resetn ? count_q : '0;

    // Write port mux: primary owns the slot whenever it is valid, even for r0.
    always_comb begin
        write_enable = 1'b0;
        wa3          = '0;
        wd3          = '0;
        if (resetn) begin
            if (prim_we) begin
                write_enable = 1'b1;
                wa3          = p_wa;
                wd3          = p_wd;
            end else if (pop) begin
                write_enable = mem_q[head_q].live;
                wa3          = mem_q[head_q].wa;
                wd3          = mem_q[head_q].wd;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop)  head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);
    end

    // Kill older entries shadowed by a primary write; a same-cycle push lands after the kill.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (prim_we && mem_q[i].wa == p_wa) begin
                    mem_q[i].live <= 1'b0;
                end
            end
            if (push) begin
                mem_q[tail_q] <= '{live: (s_wa != '0), wa: s_wa, wd: s_wd};
            end
        end
    end

    wbq_lookup #(.DEPTH(DEPTH)) u_lookup1 (
        .en_i      (resetn),
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .p_valid_i (p_valid),
        .p_wa_i    (p_wa),
        .p_wd_i    (p_wd),
        .ra_i      (q_ra1),
        .hit_o     (q_hit1),
        .data_o    (q_data1)
    );

    wbq_lookup #(.DEPTH(DEPTH)) u_lookup2 (
        .en_i      (resetn),
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .p_valid_i (p_valid),
        .p_wa_i    (p_wa),
        .p_wd_i    (p_wd),
        .ra_i      (q_ra2),
        .hit_o     (q_hit2),
        .data_o    (q_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: inputs change on negedge, outputs checked 1ns later.
module tb_wb_write_queue;

    logic        clk;
    logic        resetn;
    logic        p_valid;
    logic [4:0]  p_wa;
    logic [31:0] p_wd;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_wa;
    logic [31:0] s_wd;
    logic [4:0]  wa3;
    logic        write_enable;
    logic [31:0] wd3;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic        q_hit1;
    logic        q_hit2;
    logic [31:0] q_data1;
    logic [31:0] q_data2;
    logic [2:0]  pending;

    int checks = 0;
    int errors = 0;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .p_valid      (p_valid),
        .p_wa         (p_wa),
        .p_wd         (p_wd),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_wa         (s_wa),
        .s_wd         (s_wd),
        .wa3          (wa3),
        .write_enable (write_enable),
        .wd3          (wd3),
        .q_ra1        (q_ra1),
        .q_ra2        (q_ra2),
        .q_hit1       (q_hit1),
        .q_hit2       (q_hit2),
        .q_data1      (q_data1),
        .q_data2      (q_data2),
        .pending      (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input logic rn, input logic pv, input logic [4:0] pwa,
                       input logic [31:0] pwd, input logic sv, input logic [4:0] swa,
                       input logic [31:0] swd);
        @(negedge clk);
        resetn  = rn;
        p_valid = pv;
        p_wa    = pwa;
        p_wd    = pwd;
        s_valid = sv;
        s_wa    = swa;
        s_wd    = swd;
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wp(input string tag, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd);
        chk({tag, ".we"}, 32'(write_enable), 32'(we));
        if (we) begin
            chk({tag, ".wa"}, 32'(wa3), 32'(wa));
            chk({tag, ".wd"}, wd3, wd);
        end
    endtask

    initial begin
        resetn = 1'b0; p_valid = 1'b0; p_wa = '0; p_wd = '0;
        s_valid = 1'b0; s_wa = '0; s_wd = '0; q_ra1 = '0; q_ra2 = '0;

        // Reset held two cycles with s_valid asserted
        q_ra1 = 5'd7;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 0, 0, 1, 7, 32'h99);
            chk("rst.we", 32'(write_enable), 0);
            chk("rst.s_ready", 32'(s_ready), 0);
            chk("rst.pending", 32'(pending), 0);
            chk("rst.hit1", 32'(q_hit1), 0);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("rel.s_ready", 32'(s_ready), 1);
        chk("rel.pending", 32'(pending), 0);
        chk_wp("rel", 0, 0, 0);

        // Secondary-only drain
        cyc(1, 0, 0, 0, 1, 5, 32'h11);
        chk_wp("sec0", 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 6, 32'h22);
        chk_wp("sec1", 1, 5, 32'h11);
        chk("sec1.pending", 32'(pending), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("sec2", 1, 6, 32'h22);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("sec3", 0, 0, 0);
        chk("sec3.pending", 32'(pending), 0);

        // Primary priority while filling the FIFO
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 5'(10 + k), 32'(32'h50 + k), 1, 5'(20 + k), 32'(32'h100 + k));
            chk_wp("fill.prim", 1, 5'(10 + k), 32'(32'h50 + k));
            chk("fill.s_ready", 32'(s_ready), 1);
        end
        cyc(1, 1, 14, 32'h54, 0, 0, 0);
        chk("full.s_ready", 32'(s_ready), 0);
        chk("full.pending", 32'(pending), 4);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("drain0", 1, 20, 32'h100);
        chk("drain0.s_ready", 32'(s_ready), 0);
        for (int k = 1; k < 4; k++) begin
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk_wp("drainN", 1, 5'(20 + k), 32'(32'h100 + k));
            chk("drainN.s_ready", 32'(s_ready), 1);
        end
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("drain.pending", 32'(pending), 0);

        // Kill rule
        q_ra1 = 5'd8;
        cyc(1, 0, 0, 0, 1, 8, 32'hAA);
        chk("kill0.hit1", 32'(q_hit1), 0);
        cyc(1, 1, 8, 32'hBB, 0, 0, 0);
        chk_wp("kill1", 1, 8, 32'hBB);
        chk("kill1.data1", q_data1, 32'hBB);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("kill2.dead", 0, 0, 0);
        chk("kill2.pending", 32'(pending), 1);
        chk("kill2.hit1", 32'(q_hit1), 0);
        cyc(1, 1, 9, 32'h1, 1, 9, 32'h2);
        chk_wp("same0", 1, 9, 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("same1", 1, 9, 32'h2);

        // Forwarding
        q_ra1 = 5'd3;
        q_ra2 = 5'd0;
        cyc(1, 1, 15, 32'h77, 1, 3, 32'h1);
        cyc(1, 1, 15, 32'h78, 1, 3, 32'h2);
        chk("fwd0.hit1", 32'(q_hit1), 1);
        chk("fwd0.data1", q_data1, 32'h1);
        cyc(1, 1, 16, 32'h0, 0, 0, 0);
        chk("fwd1.hit1", 32'(q_hit1), 1);
        chk("fwd1.data1", q_data1, 32'h2);
        chk("fwd1.hit2", 32'(q_hit2), 0);
        chk("fwd1.data2", q_data2, 0);
        q_ra2 = 5'd15;
        cyc(1, 1, 3, 32'h3, 0, 0, 0);
        chk("fwd2.data1", q_data1, 32'h3);
        chk("fwd2.hit2", 32'(q_hit2), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("fwd3.hit1", 32'(q_hit1), 0);
        chk_wp("fwd3.dead", 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("fwd4.dead", 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("fwd5.pending", 32'(pending), 0);

        // r0 entries and primary r0 slot stealing
        cyc(1, 0, 0, 0, 1, 0, 32'hFF);
        cyc(1, 1, 0, 32'hEE, 0, 0, 0);
        chk_wp("r0.prim", 0, 0, 0);
        chk("r0.pending", 32'(pending), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("r0.pop", 0, 0, 0);
        chk("r0.pending2", 32'(pending), 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("r0.pending3", 32'(pending), 0);

        // Reset with entries queued
        q_ra1 = 5'd1;
        cyc(1, 1, 17, 32'h5, 1, 1, 32'hC1);
        cyc(1, 1, 17, 32'h6, 1, 2, 32'hC2);
        cyc(1, 1, 17, 32'h7, 1, 4, 32'hC4);
        cyc(1, 1, 18, 32'h8, 0, 0, 0);
        chk("mid.pending", 32'(pending), 3);
        chk("mid.hit1", 32'(q_hit1), 1);
        cyc(0, 0, 0, 0, 0, 0, 0);
        chk_wp("mid.rst", 0, 0, 0);
        chk("mid.rst.s_ready", 32'(s_ready), 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk_wp("mid.after", 0, 0, 0);
        chk("mid.after.pending", 32'(pending), 0);
        chk("mid.after.hit1", 32'(q_hit1), 0);
        chk("mid.after.s_ready", 32'(s_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
